// File: rtl/data_bus_responder.sv
// Wait-stated data-bus responder: validates load/store requests against an address
// window, accesses an internal word RAM after WAIT_CYCLES, and acknowledges for one cycle.
module data_bus_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic        err,
   output logic [31:0] rdata,
   output logic        busy
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [32:0] LIMIT     = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} stateT;

   stateT          state;
   stateT          stateNext;
   logic [3:0]     waitCnt;
   logic           errFlag;
   logic           weR;
   logic [31:0]    addrR;
   logic [3:0]     beR;
   logic [31:0]    wdataR;
   logic           addrOk;
   logic [31:0]    offset;
   logic [AW-1:0]  wordIdx;
   logic [31:0]    mem [DEPTH_WORDS];

   // 33-bit window compare so a window ending at 2^32 cannot wrap
   always_comb begin
      addrOk = (addr[1:0] == 2'b00)
             && ({1'b0, addr} >= {1'b0, BASE_ADDR})
             && ({1'b0, addr} < LIMIT);
      offset  = addrR - BASE_ADDR;
      wordIdx = AW'(offset >> 2);
   end

   always_comb begin
      stateNext = state;
      ack       = 1'b0;
      err       = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (req) begin
               if (!addrOk)
                  stateNext = RESP;
               else if (WAIT_CYCLES == 0)
                  stateNext = ACCESS;
               else
                  stateNext = WAIT;
            end
         end
         WAIT: begin
            if (waitCnt == '0)
               stateNext = ACCESS;
         end
         ACCESS: stateNext = RESP;
         RESP: begin
            ack       = 1'b1;
            err       = errFlag;
            stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         waitCnt <= '0;
         errFlag <= 1'b0;
         weR     <= 1'b0;
         addrR   <= '0;
         beR     <= '0;
         wdataR  <= '0;
         rdata   <= '0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (req) begin
                  weR     <= we;
                  addrR   <= addr;
                  beR     <= be;
                  wdataR  <= wdata;
                  errFlag <= !addrOk;
                  waitCnt <= WAIT_INIT;
                  if (!addrOk)
                     rdata <= '0;
               end
            end
            WAIT: begin
               if (waitCnt != '0)
                  waitCnt <= waitCnt - 4'd1;
            end
            ACCESS: begin
               if (!weR)
                  rdata <= mem[wordIdx];
            end
            default: ;
         endcase
      end
   end

   // RAM kept outside the reset block; a store closing under reset is dropped
   always_ff @(posedge clk) begin
      if (!rst && state == ACCESS && weR) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (beR[i])
               mem[wordIdx][8*i +: 8] <= wdataR[8*i +: 8];
         end
      end
   end

endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Memory-mapped data-bus responder that serves load/store requests issued by the MIPS32 core's data port over a req/ack handshake. It checks word alignment and the address window, then accesses an internal word-organised RAM after a programmable number of wait cycles. It returns read data, or an error, with a single-cycle acknowledge. It sits between the core's load/store path and on-chip data storage, and replaces the zero-latency data memory path when wait-stated memory is modelled.

## Interface
- `BASE_ADDR`, default 32'h10010000: virtual byte address of word 0.
- `DEPTH_WORDS`, default 512: number of 32-bit words; power of two.
- `WAIT_CYCLES`, default 2: wait cycles inserted before the RAM access; range 0..15.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `req`, in, 1: request valid; held high by the requester until `ack`.
- `we`, in, 1: 1 = store, 0 = load; sampled with `req`.
- `addr`, in, 32: virtual byte address; sampled with `req`.
- `be`, in, 4: byte enables for stores (bit i covers `wdata[8i+7:8i]`); ignored for loads.
- `wdata`, in, 32: store data; sampled with `req`.
- `ack`, out, 1: one-cycle response strobe.
- `err`, out, 1: qualifies `ack`; 1 = request rejected.
- `rdata`, out, 32: load result; valid when `ack`=1, `we` was 0 and `err`=0.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- **IDLE, `req`=1:**
  - Latch `we`, `addr`, `be`, `wdata`.
  - Compute validity: `addr[1:0]`==0 and BASE_ADDR <= `addr` < BASE_ADDR + 4*DEPTH_WORDS, using 33-bit unsigned compare with no wrap.
  - Invalid: go to RESP with error flag set.
  - Valid and WAIT_CYCLES>0: go to WAIT with counter = WAIT_CYCLES-1.
  - Valid and WAIT_CYCLES=0: go to ACCESS.
- **IDLE, `req`=0:** stay in IDLE.
- **WAIT:**
  - Counter nonzero: decrement and stay.
  - Counter zero: go to ACCESS.
  - `req` is not re-sampled in WAIT.
- **ACCESS:** one cycle. Word index = (`addr` - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
  - Store: at the closing edge, write each byte lane whose `be` bit is 1; other lanes keep their contents. `be`=0000 is legal and writes nothing.
  - Load: at the closing edge, register the full word into `rdata`.
  - Then go to RESP.
- **RESP:**
  - `ack`=1 for exactly one cycle; `err` = error flag.
  - Next state is IDLE.
  - The `req` value present during RESP is ignored.
- **`rdata` hold rules:**
  - Changes only at a load ACCESS edge, at reset, or when an error response is entered (cleared to 0 for an error response).
  - Stores and successful responses to stores leave `rdata` unchanged.
- RAM contents are not initialised or cleared by reset.

## Timing
- **Reset values:** `ack`=0, `err`=0, `busy`=0, `rdata`=0; state IDLE; counter 0; error flag 0.
- **Valid request:**
  - Acceptance edge E0 is an IDLE edge with `req`=1.
  - `ack` is high in the cycle following edge E(WAIT_CYCLES+1), i.e. WAIT_CYCLES+2 cycles after `req` was first seen high in IDLE.
  - With WAIT_CYCLES=2: `ack` rises 3 edges after E0.
- **Invalid request:** `ack`=`err`=1 in the cycle immediately after E0; no RAM access occurs.
- **`busy`:** high from the cycle after E0 through the RESP cycle inclusive.
- **Back-to-back requests:**
  - If `req` is still high in the first IDLE cycle after RESP, that is a new acceptance.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles for valid requests and 2 cycles for invalid ones.
- **Reset mid-operation:**
  - `rst` high at any edge forces IDLE and all outputs to their reset values.
  - A store whose ACCESS closing edge coincides with `rst`=1 is discarded, and no `ack` is produced for it.
- Inputs other than `req` are don't-care outside the acceptance edge.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req`=1.
  - Expect `ack`=0, `err`=0, `busy`=0, `rdata`=0 throughout.
  - Expect first acceptance at the first edge with `rst`=0.
- **Word store then load** (WAIT_CYCLES=2):
  - Store 32'hDEADBEEF to 32'h10010004 with `be`=1111; expect `ack` 3 edges after acceptance, `err`=0, `rdata` unchanged at 0.
  - Load 32'h10010004; expect `rdata`=32'hDEADBEEF coincident with `ack`.
- **Byte-lane store:**
  - Store `wdata`=32'h0000AA00 with `be`=0010 to 32'h10010004.
  - A following load returns 32'hDEADAAEF.
- **Errors:**
  - Load 32'h10010006 (misaligned): expect `ack`=`err`=1 one cycle after acceptance and `rdata`=0.
  - Store to 32'h10010800 (one past the end): expect an error response.
  - Store to 32'h1000FFFC (below base): expect an error response.
  - All three error cases leave the RAM unchanged.
- **Reset mid-store:**
  - Store 32'h12345678 to 32'h10010008 (previously 32'h0); assert `rst` for one cycle during WAIT.
  - Expect no `ack`.
  - A later load of 32'h10010008 returns 32'h0.
- **Back-to-back:**
  - Hold `req`=1 across two valid loads.
  - Expect `ack` pulses exactly 5 cycles apart.
  - Expect `busy`=0 only for the single IDLE cycle between them.
